sm3_blk_pack: RTL and testbench
===============================

// Module: sm3_blk_pack
// PURPOSE
//  Downstream neighbour of the SM3 padding stage. Packs the padded DW-bit word stream (big-endian) into 512-bit message blocks for the compression core.
//  Holds one completed block in an output register while the next block assembles. Drives the block-level enable that the padding stage samples before starting new words/blocks.
// PARAMETERS
//  DW     32   padded word width; 32 or 64 only
//  BLK_W  512  block width; WPB = BLK_W/DW words per block (16 or 8)
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      reset, asynchronous, active-low
//  clr_i      in   1      synchronous flush of both buffers and error flags
//  pad_d_i    in   DW     padded word (first word of block -> blk_d_o[BLK_W-1 -: DW])
//  pad_vld_i  in   1      word valid; no per-word backpressure, always accepted unless dropped
//  pad_lst_i  in   1      word is final word of final block of message
//  pad_ena_o  out  1      padding stage may issue words / begin a new block
//  blk_d_o    out  BLK_W  completed block
//  blk_vld_o  out  1      block valid; held stable until blk_rdy_i
//  blk_lst_o  out  1      block is last of its message
//  blk_rdy_i  in   1      consumer accepts block when blk_vld_o && blk_rdy_i
//  ovf_o      out  1      sticky: word dropped (assembly full, hold occupied)
//  err_o      out  1      sticky: pad_lst_i on a word not at slot WPB-1
// BEHAVIOUR
//  - Reset/clr_i: cnt=0, FSM=A_FILL, blk_vld_o=0, blk_d_o=0, blk_lst_o=0, ovf_o=0, err_o=0; pad_ena_o=1 the first cycle after.
//  - Reset mid-block discards partial and held blocks; nothing is emitted. clr_i has priority over all same-cycle events.
//  - hold_free = ~blk_vld_o | blk_rdy_i (consume and refill on the same edge is allowed).
//  - Assembly FSM, cnt is clog2(WPB) bits:
//    A_FILL: on pad_vld_i with cnt<WPB-1, write the word to slot cnt and cnt++.
//      On pad_vld_i with cnt==WPB-1 and hold_free: hold <= {asm, word}, blk_lst_o <= pad_lst_i, blk_vld_o=1 next cycle, cnt=0.
//      On pad_vld_i with cnt==WPB-1 and ~hold_free: store the word and go to A_FULL.
//    A_FULL: on hold_free, transfer asm to hold (blk_lst_o from latched lst) and return to A_FILL with cnt=0.
//      Any pad_vld_i in A_FULL is dropped and sets ovf_o, including in the transfer cycle.
//  - Latency: last word sampled at edge N -> blk_vld_o high after edge N (0 extra cycles) when the hold register is free.
//  - pad_ena_o = ~blk_vld_o && (state==A_FILL); combinational from registers only. The padding stage's one-cycle registered straggler after pad_ena_o falls lands in asm and is not lost.
//  - err_o is set when pad_lst_i && pad_vld_i && cnt!=WPB-1. The word is still stored, and blk_lst_o is asserted on that block when it completes.
//  - blk_d_o and blk_lst_o change only on a hold load; they never change while blk_vld_o && ~blk_rdy_i.
//  - Upstream contract: the consumer drains a held block within WPB-2 cycles of a new block's first pad-state word; otherwise ovf_o is set.
// STRUCTURE
//  - sm3_pkg holds SM3_BLK_W=512, the DW legality check (static assert), and the assembly-state enum {A_FILL, A_FULL}.
//  - One sub-module, sm3_blk_hold: BLK_W+1 valid/ready output register (load, hold_free, data/lst).
//  - The top level holds the assembly FSM, slot write decode, cnt and the error flags.
// TESTING
//  - DW=32, "abc": words 61626380, 0 x14, 00000018, lst on word 16, blk_rdy_i=1 -> one block 61626380_0..0_00000018, blk_lst_o=1, blk_vld_o the cycle after word 16.
//  - DW=64, 2 blocks back-to-back, blk_rdy_i=1 -> blocks in order, blk_lst_o 0 then 1, pad_ena_o low exactly 1 cycle per block.
//  - blk_rdy_i=0 for 40 cycles after block 1, next message straggler + pad-state words -> block 1 stable, asm enters A_FULL, extra words raise ovf_o=1.
//  - blk_rdy_i held low, then raised in the same cycle the WPB-th word arrives -> block 1 consumed, block 2 loaded on the same edge, no ovf_o.
//  - pad_lst_i at slot 5 -> err_o=1 next cycle; clr_i -> err_o=0, cnt=0, pad_ena_o=1.
//  - rst_n asserted at slot 9 with a held block -> blk_vld_o=0 immediately; next message packs from slot 0.

Source files
------------

// File: rtl/sm3_pkg.sv
// sm3_pkg: shared constants and types for the SM3 block-packing path.
//   SM3_BLK_W  - SM3 message block width in bits
//   asm_st_e   - block assembly state (filling / full and waiting on hold)
//   sm3_dw_ok  - legal padded-word widths
package sm3_pkg;

  localparam int SM3_BLK_W = 512;

  typedef enum logic {
    A_FILL = 1'b0,
    A_FULL = 1'b1
  } asm_st_e;

  function automatic bit sm3_dw_ok(input int dw);
    return (dw == 32) || (dw == 64);
  endfunction

endpackage

// File: rtl/sm3_blk_hold.sv
// sm3_blk_hold: valid/ready output register for one completed block
// (data plus last-of-message flag).
//   clk, rst_n  clock, async active-low reset
//   i_clr       synchronous flush (wins over load)
//   i_ld        load i_d/i_lst; caller only loads when o_free
//   i_d, i_lst  block data and last flag to load
//   i_rdy       consumer ready
//   o_vld       block valid, held until i_rdy
//   o_d, o_lst  held block; only change on a load
//   o_free      register can take a load this cycle
module sm3_blk_hold #(
  parameter int BLK_W = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_ld,
  input  logic [BLK_W-1:0] i_d,
  input  logic             i_lst,
  input  logic             i_rdy,
  output logic             o_vld,
  output logic [BLK_W-1:0] o_d,
  output logic             o_lst,
  output logic             o_free
);

  logic             r_vld;
  logic [BLK_W-1:0] r_d;
  logic             r_lst;

  // Consume and refill on the same edge is allowed.
  assign o_free = ~r_vld | i_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_d   <= '0;
      r_lst <= 1'b0;
    end else if (i_clr) begin
      r_vld <= 1'b0;
      r_d   <= '0;
      r_lst <= 1'b0;
    end else if (i_ld) begin
      r_vld <= 1'b1;
      r_d   <= i_d;
      r_lst <= i_lst;
    end else if (i_rdy) begin
      r_vld <= 1'b0;
    end
  end

  assign o_vld = r_vld;
  assign o_d   = r_d;
  assign o_lst = r_lst;

endmodule

// File: rtl/sm3_blk_pack.sv
// sm3_blk_pack: packs the padded big-endian word stream into BLK_W-bit
// blocks for the SM3 compression core, double-buffered (assembly + hold).
//   clk, rst_n        clock, async active-low reset
//   clr_i             synchronous flush of both buffers and error flags
//   pad_d_i/vld/lst   padded word in; first word lands in the block MSBs
//   pad_ena_o         padding stage may issue words / start a block
//   blk_d_o/vld/lst   completed block out, valid/ready with blk_rdy_i
//   ovf_o             sticky: word dropped while assembly and hold full
//   err_o             sticky: last flag seen away from the final slot
module sm3_blk_pack
  import sm3_pkg::*;
#(
  parameter int DW    = 32,
  parameter int BLK_W = SM3_BLK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [DW-1:0]    pad_d_i,
  input  logic             pad_vld_i,
  input  logic             pad_lst_i,
  output logic             pad_ena_o,
  output logic [BLK_W-1:0] blk_d_o,
  output logic             blk_vld_o,
  output logic             blk_lst_o,
  input  logic             blk_rdy_i,
  output logic             ovf_o,
  output logic             err_o
);

  localparam int WPB = BLK_W / DW;
  localparam int CW  = $clog2(WPB);
  localparam logic [CW-1:0] LAST = CW'(WPB - 1);

  if (!sm3_dw_ok(DW) || BLK_W != SM3_BLK_W) begin : g_bad_param
    $error("sm3_blk_pack: DW must be 32 or 64 and BLK_W 512");
  end

  // Element WPB-1 is slot 0 so the packed array is the block, MSB first.
  logic [WPB-1:0][DW-1:0] r_asm;
  logic [CW-1:0]          r_cnt;
  asm_st_e                r_st;
  logic                   r_lst;
  logic                   r_ovf;
  logic                   r_err;

  logic             w_free;
  logic             w_last_slot;
  logic             w_ld;
  logic [BLK_W-1:0] w_ld_d;
  logic             w_ld_lst;

  assign w_last_slot = (r_cnt == LAST);

  // From A_FILL the final word bypasses asm straight into hold; from A_FULL
  // asm already holds every word.
  assign w_ld = (r_st == A_FULL) ? w_free
                                 : (pad_vld_i & w_last_slot & w_free);
  assign w_ld_d   = (r_st == A_FULL) ? r_asm : {r_asm[WPB-1:1], pad_d_i};
  assign w_ld_lst = (r_st == A_FULL) ? r_lst : (r_lst | pad_lst_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm <= '0;
      r_cnt <= '0;
      r_st  <= A_FILL;
      r_lst <= 1'b0;
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else if (clr_i) begin
      r_asm <= '0;
      r_cnt <= '0;
      r_st  <= A_FILL;
      r_lst <= 1'b0;
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      case (r_st)
        A_FILL: begin
          if (pad_vld_i) begin
            r_asm[LAST - r_cnt] <= pad_d_i;
            // A misplaced last flag is flagged but the block still closes
            // normally and is marked last.
            if (pad_lst_i && !w_last_slot) r_err <= 1'b1;
            if (!w_last_slot) begin
              r_cnt <= r_cnt + 1'b1;
              r_lst <= r_lst | pad_lst_i;
            end else if (w_free) begin
              r_cnt <= '0;
              r_lst <= 1'b0;
            end else begin
              // cnt stays at LAST while full
              r_lst <= r_lst | pad_lst_i;
              r_st  <= A_FULL;
            end
          end
        end
        A_FULL: begin
          if (pad_vld_i) r_ovf <= 1'b1;
          if (w_free) begin
            r_cnt <= '0;
            r_lst <= 1'b0;
            r_st  <= A_FILL;
          end
        end
        default: r_st <= A_FILL;
      endcase
    end
  end

  sm3_blk_hold #(.BLK_W(BLK_W)) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (clr_i),
    .i_ld   (w_ld),
    .i_d    (w_ld_d),
    .i_lst  (w_ld_lst),
    .i_rdy  (blk_rdy_i),
    .o_vld  (blk_vld_o),
    .o_d    (blk_d_o),
    .o_lst  (blk_lst_o),
    .o_free (w_free)
  );

  assign pad_ena_o = ~blk_vld_o & (r_st == A_FILL);
  assign ovf_o     = r_ovf;
  assign err_o     = r_err;

endmodule

// File: tb/tb_sm3_blk_pack.sv
module tb_sm3_blk_pack;

  typedef struct {
    logic [511:0] d;
    logic         l;
  } exp_t;

  logic clk, rst_n;
  // DW=32 instance
  logic         clr, pv, pl, rdy, ena, bv, bl, ovf, err;
  logic [31:0]  pd;
  logic [511:0] bd;
  // DW=64 instance
  logic         clr64, pv64, pl64, rdy64, ena64, bv64, bl64, ovf64, err64;
  logic [63:0]  pd64;
  logic [511:0] bd64;

  int ntest = 0;
  int nfail = 0;
  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;
  bit   cnt64_en = 0;
  int   low64 = 0;

  sm3_blk_pack #(.DW(32), .BLK_W(512)) dut32 (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .pad_d_i(pd), .pad_vld_i(pv),
    .pad_lst_i(pl), .pad_ena_o(ena), .blk_d_o(bd), .blk_vld_o(bv),
    .blk_lst_o(bl), .blk_rdy_i(rdy), .ovf_o(ovf), .err_o(err));

  sm3_blk_pack #(.DW(64), .BLK_W(512)) dut64 (
    .clk(clk), .rst_n(rst_n), .clr_i(clr64), .pad_d_i(pd64), .pad_vld_i(pv64),
    .pad_lst_i(pl64), .pad_ena_o(ena64), .blk_d_o(bd64), .blk_vld_o(bv64),
    .blk_lst_o(bl64), .blk_rdy_i(rdy64), .ovf_o(ovf64), .err_o(err64));

  initial clk = 0;
  always #5 clk = ~clk;

  // Scoreboards: every block the consumer accepts is popped and compared.
  always @(negedge clk) begin
    if (rst_n && bv && rdy) begin
      ntest++;
      if (q32.size() == 0) begin
        nfail++;
        $display("FAIL blk32_unexpected got %h exp none", bd);
      end else begin
        e32 = q32.pop_front();
        if (bd !== e32.d || bl !== e32.l) begin
          nfail++;
          $display("FAIL blk32 got %h lst %b exp %h lst %b", bd, bl, e32.d, e32.l);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cnt64_en && !ena64) low64++;
    if (rst_n && bv64 && rdy64) begin
      ntest++;
      if (q64.size() == 0) begin
        nfail++;
        $display("FAIL blk64_unexpected got %h exp none", bd64);
      end else begin
        e64 = q64.pop_front();
        if (bd64 !== e64.d || bl64 !== e64.l) begin
          nfail++;
          $display("FAIL blk64 got %h lst %b exp %h lst %b", bd64, bl64, e64.d, e64.l);
        end
      end
    end
  end

  // All tasks start and end at posedge+#1.
  task automatic send32(input logic [31:0] w, input logic l);
    pd = w; pl = l; pv = 1'b1;
    @(posedge clk); #1;
    pv = 1'b0; pl = 1'b0;
  endtask

  // Random block; rdy is raised together with word rdy_at (-1: untouched).
  task automatic send_blk32(input logic lst, input int rdy_at);
    logic [31:0] w[16];
    exp_t e;
    e.d = '0; e.l = lst;
    for (int i = 0; i < 16; i++) begin
      w[i] = $urandom;
      e.d = {e.d[479:0], w[i]};
    end
    q32.push_back(e);
    for (int i = 0; i < 16; i++) begin
      if (i == rdy_at) rdy = 1'b1;
      send32(w[i], (i == 15) ? lst : 1'b0);
    end
  endtask

  task automatic chk_q32_empty(input string nm);
    ntest++;
    if (q32.size() != 0) begin
      nfail++;
      $display("FAIL %s pending got %0d exp 0", nm, q32.size());
    end
  endtask

  task automatic pulse_clr;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic test_reset;
    logic [6:0] got, exp;
    got = {bv, bl, ovf, err, ena, ena64, bv64};
    exp = 7'b0000110;
    ntest++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL reset_flags got %b exp %b", got, exp);
    end
    ntest++;
    if (bd !== '0) begin
      nfail++;
      $display("FAIL reset_data got %h exp 0", bd);
    end
  endtask

  task automatic test_abc;
    exp_t e;
    rdy = 1'b1;
    e.d = '0; e.d[511 -: 32] = 32'h61626380; e.d[31:0] = 32'h00000018; e.l = 1'b1;
    q32.push_back(e);
    send32(32'h61626380, 1'b0);
    for (int i = 0; i < 14; i++) send32(32'h0, 1'b0);
    send32(32'h00000018, 1'b1);
    ntest++;
    if (bv !== 1'b1 || ena !== 1'b0) begin
      nfail++;
      $display("FAIL abc_latency got vld %b ena %b exp vld 1 ena 0", bv, ena);
    end
    repeat (2) @(posedge clk); #1;
    chk_q32_empty("abc");
  endtask

  task automatic test_back_to_back64;
    logic [63:0] w[16];
    exp_t e;
    rdy64 = 1'b1;
    for (int b = 0; b < 2; b++) begin
      e.d = '0; e.l = (b == 1);
      for (int i = 0; i < 8; i++) begin
        w[b*8+i] = {$urandom, $urandom};
        e.d = {e.d[447:0], w[b*8+i]};
      end
      q64.push_back(e);
    end
    low64 = 0; cnt64_en = 1;
    for (int i = 0; i < 16; i++) begin
      pd64 = w[i]; pl64 = (i == 15); pv64 = 1'b1;
      @(posedge clk); #1;
    end
    pv64 = 1'b0; pl64 = 1'b0;
    repeat (3) @(posedge clk); #1;
    cnt64_en = 0;
    ntest++;
    if (low64 != 2) begin
      nfail++;
      $display("FAIL b2b64_ena_low got %0d exp 2", low64);
    end
    ntest++;
    if (q64.size() != 0) begin
      nfail++;
      $display("FAIL b2b64 pending got %0d exp 0", q64.size());
    end
  endtask

  task automatic test_stall;
    logic [511:0] held;
    bit stable;
    rdy = 1'b0;
    send_blk32(1'b0, -1);
    held = q32[0].d;
    send_blk32(1'b1, -1);
    ntest++;
    if (ena !== 1'b0 || ovf !== 1'b0) begin
      nfail++;
      $display("FAIL stall_full got ena %b ovf %b exp ena 0 ovf 0", ena, ovf);
    end
    stable = 1;
    repeat (40) begin
      @(negedge clk);
      if (bd !== held || bv !== 1'b1) stable = 0;
    end
    @(posedge clk); #1;
    ntest++;
    if (!stable) begin
      nfail++;
      $display("FAIL stall_hold_stable got %h exp %h", bd, held);
    end
    send32($urandom, 1'b0);
    send32($urandom, 1'b0);
    ntest++;
    if (ovf !== 1'b1) begin
      nfail++;
      $display("FAIL stall_ovf got %b exp 1", ovf);
    end
    rdy = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk_q32_empty("stall_drain");
    pulse_clr;
  endtask

  task automatic test_same_edge;
    rdy = 1'b0;
    send_blk32(1'b0, -1);
    send_blk32(1'b1, 15);
    ntest++;
    if (ovf !== 1'b0) begin
      nfail++;
      $display("FAIL same_edge_ovf got %b exp 0", ovf);
    end
    repeat (2) @(posedge clk); #1;
    chk_q32_empty("same_edge");
  endtask

  task automatic test_err_clr;
    rdy = 1'b1;
    for (int i = 0; i < 5; i++) send32($urandom, 1'b0);
    send32($urandom, 1'b1);
    ntest++;
    if (err !== 1'b1) begin
      nfail++;
      $display("FAIL err_set got %b exp 1", err);
    end
    pulse_clr;
    ntest++;
    if (err !== 1'b0 || ena !== 1'b1 || bv !== 1'b0) begin
      nfail++;
      $display("FAIL clr_state got err %b ena %b vld %b exp 0 1 0", err, ena, bv);
    end
    send_blk32(1'b0, -1);
    repeat (2) @(posedge clk); #1;
    chk_q32_empty("after_clr");
  endtask

  task automatic test_reset_mid;
    rdy = 1'b0;
    send_blk32(1'b0, -1);
    for (int i = 0; i < 9; i++) send32($urandom, 1'b0);
    rst_n = 1'b0;
    #1;
    ntest++;
    if (bv !== 1'b0 || ena !== 1'b1) begin
      nfail++;
      $display("FAIL reset_mid got vld %b ena %b exp 0 1", bv, ena);
    end
    q32.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy = 1'b1;
    send_blk32(1'b1, -1);
    repeat (2) @(posedge clk); #1;
    chk_q32_empty("reset_mid_repack");
  endtask

  initial begin
    rst_n = 0; clr = 0; pv = 0; pl = 0; pd = '0; rdy = 0;
    clr64 = 0; pv64 = 0; pl64 = 0; pd64 = '0; rdy64 = 0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1;
    test_reset;
    test_abc;
    test_back_to_back64;
    test_stall;
    test_same_edge;
    test_err_clr;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
